// File: rtl/mistral_lut_cfg_port_if.sv
// Byte-stream configuration bus for the Mistral LUT configuration port.
// The host side (master) pushes header/mask bytes and drains readback bytes;
// the LUT bank (slave) accepts configuration bytes and sources readback bytes.
interface mistral_lut_cfg_port_if;
  logic       CFG_VALID;
  logic       CFG_READY;
  logic [7:0] CFG_DATA;
  logic       RD_VALID;
  logic       RD_READY;
  logic [7:0] RD_DATA;

  modport master (
    output CFG_VALID,
    output CFG_DATA,
    output RD_READY,
    input  CFG_READY,
    input  RD_VALID,
    input  RD_DATA
  );

  modport slave (
    input  CFG_VALID,
    input  CFG_DATA,
    input  RD_READY,
    output CFG_READY,
    output RD_VALID,
    output RD_DATA
  );
endinterface

// File: rtl/mistral_lut_cfg_port.sv
// Runtime configuration port for a bank of NLUT Mistral LUT6 evaluators.
// Write frames (header + 8 mask bytes, LSB byte first) load a shadow register
// that is committed to one mask in a single edge; read frames stream a
// snapshot of one mask back out. Q evaluates every LUT combinationally from
// the committed masks, so it never shows a partially written mask.
module mistral_lut_cfg_port #(
  parameter int          NLUT = 4,
  parameter logic [63:0] INIT = 64'h0000_0000_0000_0000
) (
  input  logic                  CLK,
  input  logic                  SCLR,
  mistral_lut_cfg_port_if.slave cfg,
  input  logic [6*NLUT-1:0]     LUT_IN,
  output logic [NLUT-1:0]       Q,
  output logic                  ERR,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [3:0]  idx;
  logic        idx_ok;
  logic [63:0] shadow;
  logic [63:0] snap;
  logic [63:0] mask [NLUT];

  logic        cfg_ready_q;
  logic        rd_valid_q;
  logic [7:0]  rd_data_q;

  logic        cfg_fire;
  logic        rd_fire;
  logic [3:0]  hdr_idx;
  logic        hdr_ok;
  logic [63:0] hdr_mask;
  logic [63:0] wr_word;
  logic [2:0]  cnt_nxt;

  assign cfg.CFG_READY = cfg_ready_q;
  assign cfg.RD_VALID  = rd_valid_q;
  assign cfg.RD_DATA   = rd_data_q;

  assign cfg_fire = cfg.CFG_VALID && cfg_ready_q;
  assign rd_fire  = rd_valid_q && cfg.RD_READY;
  assign hdr_idx  = cfg.CFG_DATA[3:0];
  assign hdr_ok   = ({1'b0, hdr_idx} < 5'(NLUT));
  assign cnt_nxt  = cnt + 3'd1;

  // Select the mask addressed by the incoming header, for the read snapshot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hdr_mask = '0;
    for (int i = 0; i < NLUT; i++) begin
      if (hdr_idx == 4'(i)) hdr_mask = mask[i];
    end
  end

  // Merge the incoming byte into the shadow word at byte position cnt.
  always_comb begin
    wr_word                     = shadow;
    wr_word[{cnt, 3'b000} +: 8] = cfg.CFG_DATA;
  end

  // Evaluate every LUT6: its 6-bit input slice selects one mask bit.
  always_comb begin
    Q = '0;
    for (int i = 0; i < NLUT; i++) begin
      Q[i] = mask[i][LUT_IN[6*i +: 6]];
    end
  end

  // Frame FSM: header decode, byte collection, commit, readback and error pulse.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (SCLR) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      idx         <= 4'd0;
      idx_ok      <= 1'b0;
      shadow      <= '0;
      snap        <= '0;
      cfg_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'h00;
      ERR         <= 1'b0;
      BUSY        <= 1'b0;
      // NOTE: the mask bank is deliberately reset; Q must show INIT right after SCLR.
      for (int i = 0; i < NLUT; i++) mask[i] <= INIT;
    end else begin
      ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_fire) begin
            cnt    <= 3'd0;
            idx    <= hdr_idx;
            idx_ok <= hdr_ok;
            if (cfg.CFG_DATA[7]) begin
              // Writes to a bad index still consume their 8 bytes.
              state <= WDATA;
              BUSY  <= 1'b1;
            end else if (hdr_ok) begin
              state       <= RDATA;
              BUSY        <= 1'b1;
              cfg_ready_q <= 1'b0;
              rd_valid_q  <= 1'b1;
              snap        <= hdr_mask;
              rd_data_q   <= hdr_mask[7:0];
            end else begin
              ERR <= 1'b1;
            end
          end
        end

        WDATA: begin
          if (cfg_fire) begin
            shadow <= wr_word;
            if (cnt == 3'd7) begin
              state <= IDLE;
              BUSY  <= 1'b0;
              cnt   <= 3'd0;
              if (idx_ok) begin
                for (int i = 0; i < NLUT; i++) begin
                  if (idx == 4'(i)) mask[i] <= wr_word;
                end
              end else begin
                ERR <= 1'b1;
              end
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end

        RDATA: begin
          if (rd_fire) begin
            if (cnt == 3'd7) begin
              state       <= IDLE;
              BUSY        <= 1'b0;
              cnt         <= 3'd0;
              cfg_ready_q <= 1'b1;
              rd_valid_q  <= 1'b0;
              rd_data_q   <= 8'h00;
            end else begin
              cnt       <= cnt_nxt;
              rd_data_q <= snap[{cnt_nxt, 3'b000} +: 8];
            end
          end
        end

        default: begin
          state       <= IDLE;
          BUSY        <= 1'b0;
          cnt         <= 3'd0;
          cfg_ready_q <= 1'b1;
          rd_valid_q  <= 1'b0;
          rd_data_q   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mistral_lut_cfg_port.sv
// Directed self-checking bench for mistral_lut_cfg_port (NLUT=4, INIT=AND6).
module tb_mistral_lut_cfg_port;

  localparam int          NLUT = 4;
  localparam logic [63:0] INIT = 64'h8000_0000_0000_0000;

  logic              clk;
  logic              sclr;
  logic [6*NLUT-1:0] lut_in;
  logic [NLUT-1:0]   q;
  logic              err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_mask [NLUT];

  mistral_lut_cfg_port_if bus ();

  mistral_lut_cfg_port #(
    .NLUT (NLUT),
    .INIT (INIT)
  ) dut (
    .CLK    (clk),
    .SCLR   (sclr),
    .cfg    (bus),
    .LUT_IN (lut_in),
    .Q      (q),
    .ERR    (err),
    .BUSY   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench model of the LUT bank outputs.
  function automatic logic [NLUT-1:0] exp_q(input logic [6*NLUT-1:0] li);
    logic [NLUT-1:0] r;
    r = '0;
    for (int i = 0; i < NLUT; i++) r[i] = exp_mask[i][li[6*i +: 6]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic cfg_send(input logic [7:0] b);
    int budget;
    bus.CFG_VALID = 1'b1;
    bus.CFG_DATA  = b;
    budget = 0;
    while (bus.CFG_READY !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    if (budget >= 50) begin
      checks++; errors++;
      $display("FAIL cfg_send_timeout: CFG_READY=%b required 1", bus.CFG_READY);
    end
    tick();
    bus.CFG_VALID = 1'b0;
  endtask

  task automatic write_frame(input logic [3:0] idx, input logic [63:0] m);
    cfg_send({4'h8, idx});
    for (int b = 0; b < 8; b++) cfg_send(m[8*b +: 8]);
    if (idx < 4'(NLUT)) exp_mask[idx] = m;
  endtask

  task automatic do_reset(input int cycles);
    sclr = 1'b1;
    repeat (cycles) tick();
    sclr = 1'b0;
    for (int i = 0; i < NLUT; i++) exp_mask[i] = INIT;
  endtask

  task automatic test_reset();
    bus.CFG_VALID = 1'b0;
    bus.CFG_DATA  = 8'h00;
    bus.RD_READY  = 1'b0;
    lut_in        = '0;
    do_reset(2);
    checks++; if (bus.CFG_READY !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b required 1", bus.CFG_READY); end
    checks++; if (bus.RD_VALID !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b required 0", bus.RD_VALID); end
    checks++; if (bus.RD_DATA !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h required 00", bus.RD_DATA); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    lut_in = {6'h3F, 6'h3F, 6'h3F, 6'h3F}; #1;
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL reset_q_all3f: got %h required f", q); end
    lut_in = {6'h3E, 6'h1F, 6'h00, 6'h3B}; #1;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q_near3f: got %h required 0", q); end
    lut_in = {6'h01, 6'h3F, 6'h00, 6'h3F}; #1;
    checks++; if (q !== 4'b0101) begin errors++; $display("FAIL reset_q_mixed: got %h required 5", q); end
  endtask

  task automatic test_write_apply();
    lut_in = {6'h3F, 6'h01, 6'h3F, 6'h3F}; #1;
    cfg_send(8'h82);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_after_hdr: got %b required 1", busy); end
    for (int b = 0; b < 7; b++) begin
      cfg_send(8'hAA);
      checks++; if (q !== 4'b1011) begin errors++; $display("FAIL wr_q_partial byte %0d: got %h required b", b + 1, q); end
    end
    cfg_send(8'hAA);
    exp_mask[2] = 64'hAAAA_AAAA_AAAA_AAAA;
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL wr_q_commit: got %h required f", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b required 0", busy); end
    lut_in = {6'h3F, 6'h02, 6'h3F, 6'h3F}; #1;
    checks++; if (q !== 4'b1011) begin errors++; $display("FAIL wr_q_a0: got %h required b", q); end
    lut_in = {6'h00, 6'h3F, 6'h00, 6'h00}; #1;
    checks++; if (q !== exp_q(lut_in)) begin errors++; $display("FAIL wr_q_others: got %h required %h", q, exp_q(lut_in)); end
  endtask

  task automatic test_readback();
    logic [63:0] word;
    logic [15:0] pat;
    logic [7:0]  exp_b;
    logic        r;
    int          n;
    int          cyc;
    word = 64'h0123_4567_89AB_CDEF;
    pat  = 16'b1011_0010_0110_1101;
    write_frame(4'd1, word);
    cfg_send(8'h01);
    // A write header offered during readback must be ignored.
    bus.CFG_VALID = 1'b1;
    bus.CFG_DATA  = 8'h83;
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 40) begin
      exp_b = word[8*n +: 8];
      checks++; if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== exp_b) begin errors++; $display("FAIL rd_byte %0d: valid=%b data=%h required valid=1 data=%h", n, bus.RD_VALID, bus.RD_DATA, exp_b); end
      checks++; if (bus.CFG_READY !== 1'b0) begin errors++; $display("FAIL rd_cfg_ready byte %0d: got %b required 0", n, bus.CFG_READY); end
      r = pat[cyc % 16];
      bus.RD_READY = r;
      tick();
      if (r) n++;
      cyc++;
    end
    bus.RD_READY  = 1'b0;
    bus.CFG_VALID = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL rd_timeout: got %0d bytes required 8", n); end
    checks++; if (bus.RD_VALID !== 1'b0) begin errors++; $display("FAIL rd_valid_end: got %b required 0", bus.RD_VALID); end
    checks++; if (bus.CFG_READY !== 1'b1) begin errors++; $display("FAIL rd_cfg_ready_end: got %b required 1", bus.CFG_READY); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after: got %b required 0", busy); end
    lut_in = {6'h00, 6'h00, 6'h00, 6'h00}; #1;
    checks++; if (q !== exp_q(lut_in)) begin errors++; $display("FAIL rd_q_unchanged: got %h required %h", q, exp_q(lut_in)); end
  endtask

  task automatic test_bad_index();
    lut_in = {6'h3F, 6'h01, 6'h00, 6'h3F}; #1;
    cfg_send(8'h85);
    for (int b = 0; b < 8; b++) begin
      checks++; if (bus.CFG_READY !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL bad_wr_byte %0d: ready=%b err=%b required ready=1 err=0", b, bus.CFG_READY, err); end
      cfg_send(8'hFF);
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_wr_err: got %b required 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_wr_busy: got %b required 0", busy); end
    checks++; if (q !== exp_q(lut_in)) begin errors++; $display("FAIL bad_wr_q: got %h required %h", q, exp_q(lut_in)); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_wr_err_width: got %b required 0", err); end
    cfg_send(8'h07);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_rd_err: got %b required 1", err); end
    checks++; if (bus.RD_VALID !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bad_rd_state: rd_valid=%b busy=%b required 0 0", bus.RD_VALID, busy); end
    tick();
    checks++; if (err !== 1'b0 || bus.RD_VALID !== 1'b0) begin errors++; $display("FAIL bad_rd_after: err=%b rd_valid=%b required 0 0", err, bus.RD_VALID); end
  endtask

  task automatic test_reset_mid_write();
    cfg_send(8'h80);
    for (int b = 0; b < 4; b++) cfg_send(8'h55);
    do_reset(1);
    checks++; if (busy !== 1'b0 || bus.CFG_READY !== 1'b1) begin errors++; $display("FAIL rst_mid_state: busy=%b ready=%b required 0 1", busy, bus.CFG_READY); end
    lut_in = {6'h3F, 6'h3F, 6'h3F, 6'h3F}; #1;
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL rst_mid_q_init: got %h required f", q); end
    lut_in = {6'h02, 6'h01, 6'h00, 6'h00}; #1;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL rst_mid_q_zero: got %h required 0", q); end
    write_frame(4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (q !== 4'b0001) begin errors++; $display("FAIL rst_mid_q_ones: got %h required 1", q); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_mid_end: busy=%b err=%b required 0 0", busy, err); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m0;
    logic [63:0] m3;
    logic [7:0]  bytes [18];
    m0 = 64'hFFFF_FFFF_FFFF_FFFE;
    m3 = 64'h0000_0000_0000_0001;
    bytes[0] = 8'h80;
    bytes[9] = 8'h83;
    for (int b = 0; b < 8; b++) begin
      bytes[1 + b]  = m0[8*b +: 8];
      bytes[10 + b] = m3[8*b +: 8];
    end
    lut_in = {6'h00, 6'h3F, 6'h3F, 6'h00}; #1;
    bus.CFG_VALID = 1'b1;
    for (int k = 0; k < 18; k++) begin
      checks++; if (bus.CFG_READY !== 1'b1) begin errors++; $display("FAIL b2b_accept %0d: got %b required 1", k + 1, bus.CFG_READY); end
      bus.CFG_DATA = bytes[k];
      tick();
      if (k == 7) begin
        checks++; if (q[0] !== 1'b1) begin errors++; $display("FAIL b2b_q0_early: got %b required 1", q[0]); end
      end
      if (k == 8) begin
        checks++; if (q[0] !== 1'b0) begin errors++; $display("FAIL b2b_q0_commit: got %b required 0", q[0]); end
      end
      if (k == 16) begin
        checks++; if (q[3] !== 1'b0) begin errors++; $display("FAIL b2b_q3_early: got %b required 0", q[3]); end
      end
    end
    bus.CFG_VALID = 1'b0;
    exp_mask[0] = m0;
    exp_mask[3] = m3;
    checks++; if (q !== exp_q(lut_in)) begin errors++; $display("FAIL b2b_q_final: got %h required %h", q, exp_q(lut_in)); end
    checks++; if (q[3] !== 1'b1) begin errors++; $display("FAIL b2b_q3_commit: got %b required 1", q[3]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b required 0", busy); end
  endtask

  initial begin
    sclr = 1'b1;
    test_reset();
    test_write_apply();
    test_readback();
    test_bad_index();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
